data_ram: RTL and testbench

//  - Word-addressed data memory for the 16-bit CPU datapath.
//  - Synchronous write, combinational read. The CPU drives address, write data and write enable.
//  - Read data (inM_o) is returned in the same cycle and feeds the ALU/A-D register path.
//  - Reset invalidates every word, so all locations read 0 until written.

---
 rtl/data_ram_pkg.sv | 17 +
 rtl/data_ram_valid.sv | 25 ++
 rtl/data_ram.sv | 63 ++++++
 tb/tb_data_ram.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared sizes, types and address helper for the data memory.
package data_ram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16384;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [IDX_W-1:0]  idx_t;

    function automatic logic in_range(addr_t a);
        return 32'(a) < DEPTH;
    endfunction

endpackage

// File: rtl/data_ram_valid.sv
// Per-word valid bits: async clear, synchronous set, combinational lookup.
module data_ram_valid
    import data_ram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic setEn,
    input  idx_t setIdx,
    input  idx_t lookIdx,
    output logic isValid
);

    logic [DEPTH-1:0] validQ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            validQ <= '0;
        end else if (setEn) begin
            validQ[setIdx] <= 1'b1;
        end
    end

    assign isValid = validQ[lookIdx];

endmodule

// File: rtl/data_ram.sv
// Word-addressed data memory: sync write, combinational read, reset invalidates.
// Optional even parity per word when DATA_RAM_PARITY_EN is defined.
module data_ram
    import data_ram_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  writeM_i,
    input  addr_t addressM_i,
    input  word_t outM_i,
`ifdef DATA_RAM_PARITY_EN
    output logic  parity_err_o,
`endif
    output word_t inM_o
);

    word_t mem [DEPTH];
    logic  inRange;
    logic  wrEn;
    logic  wordValid;
    idx_t  idx;

    assign inRange = in_range(addressM_i);
    assign idx     = addressM_i[IDX_W-1:0];
    // Gate with reset so a write landing on an asserted reset is dropped
    assign wrEn    = rst_ni && writeM_i && inRange;

    data_ram_valid uValid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .setEn   (wrEn),
        .setIdx  (idx),
        .lookIdx (idx),
        .isValid (wordValid)
    );

    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            mem[idx] <= outM_i;
        end
    end

    assign inM_o = (inRange && wordValid) ? mem[idx] : '0;

`ifdef DATA_RAM_PARITY_EN
    logic parMem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            parMem[idx] <= ^outM_i;
        end
    end

    assign parity_err_o = inRange && wordValid
                        && ((^mem[idx]) != parMem[idx]);
`endif

    wrAddrKnown: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        writeM_i |-> !$isunknown(addressM_i)
    );

endmodule

// File: tb/tb_data_ram.sv
// Randomized bench for data_ram against an associative-array memory model.
module tb_data_ram;
    import data_ram_pkg::*;

    logic  clk = 1'b0;
    logic  rstN;
    logic  writeM;
    addr_t addressM;
    word_t outM;
    word_t inM;
`ifdef DATA_RAM_PARITY_EN
    logic  parityErr;
`endif

    int checks = 0;
    int errors = 0;

    word_t refMem [int];

    data_ram dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .writeM_i     (writeM),
        .addressM_i   (addressM),
        .outM_i       (outM),
`ifdef DATA_RAM_PARITY_EN
        .parity_err_o (parityErr),
`endif
        .inM_o        (inM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got,
                         input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t refRead(input int a);
        if (a < DEPTH && refMem.exists(a)) return refMem[a];
        return '0;
    endfunction

    // Called just after a posedge: drive, check old contents, take the edge
    task automatic step(input logic we, input int a, input word_t d);
        writeM   = we;
        addressM = addr_t'(a);
        outM     = d;
        #1;
        check("preEdge", inM, refRead(a));
        @(posedge clk);
        if (we && a < DEPTH) refMem[a] = d;
        #1;
    endtask

    task automatic peek(input string tag, input int a,
                        input word_t exp);
        writeM   = 1'b0;
        addressM = addr_t'(a);
        #1;
        check(tag, inM, exp);
    endtask

    initial begin
        rstN     = 1'b0;
        writeM   = 1'b0;
        addressM = '0;
        outM     = '0;
        #2;
        for (int a = 0; a < 16; a++) peek("rstRead", a, 16'h0000);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int a = 0; a < 16; a++) peek("postRst", a, 16'h0000);
        @(posedge clk);
        #1;

        for (int k = 0; k <= 10; k++) step(1'b1, k, word_t'(k));
        for (int k = 0; k <= 10; k++) peek("fill", k, word_t'(k));
        for (int k = 11; k < 16; k++) peek("unfilled", k, 16'h0000);

        writeM   = 1'b1;
        addressM = 16'd5;
        outM     = 16'hBEEF;
        #1;
        check("sameOld", inM, 16'h0005);
        @(posedge clk);
        refMem[5] = 16'hBEEF;
        #1;
        check("sameNew", inM, 16'hBEEF);

        step(1'b1, 16384, 16'h1234);
        peek("oorRead", 16384, 16'h0000);
        peek("oorAlias", 0, 16'h0000);
        step(1'b1, 65535, 16'h5678);
        peek("oorTop", 65535, 16'h0000);
        peek("lastOk", DEPTH - 1, refRead(DEPTH - 1));

        // Write enable pulsed between edges but low at the edge
        writeM   = 1'b1;
        addressM = 16'd7;
        outM     = 16'hAAAA;
        #2;
        writeM = 1'b0;
        @(posedge clk);
        #1;
        peek("glitchWe", 7, 16'h0007);

        repeat (400) begin
            int a;
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 31);
                1: a = DEPTH - 16 + $urandom_range(0, 31);
                default: a = $urandom_range(0, 65535);
            endcase
            if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 31);
            step(1'($urandom_range(0, 1)), a, word_t'($urandom));
        end
        for (int a = 0; a < 32; a++) peek("randSweep", a, refRead(a));

`ifdef DATA_RAM_PARITY_EN
        step(1'b1, 1, 16'h0F0F);
        step(1'b1, 2, 16'h1234);
        peek("parOk", 2, 16'h1234);
        check("parOk", word_t'(parityErr), 16'h0000);
        dut.mem[2][0] = ~dut.mem[2][0];
        peek("parFlip", 2, 16'h1235);
        check("parFlip", word_t'(parityErr), 16'h0001);
        peek("parAddr1", 1, 16'h0F0F);
        check("parAddr1", word_t'(parityErr), 16'h0000);
        refMem[2] = 16'h1235;
`endif

        step(1'b1, 3, 16'h3333);
        writeM   = 1'b1;
        addressM = 16'd3;
        outM     = 16'h7777;
        #1;
        check("rstBefore", inM, 16'h3333);
        rstN = 1'b0;
        #1;
        check("rstAsync", inM, 16'h0000);
        refMem.delete();
        @(posedge clk);
        #2;
        rstN   = 1'b1;
        writeM = 1'b0;
        #1;
        check("rstWrite", inM, 16'h0000);
        for (int a = 0; a < 16; a++) peek("rstSweep", a, 16'h0000);
        step(1'b1, 3, 16'hC0DE);
        peek("afterRst", 3, 16'hC0DE);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
